// File: rtl/counter_bank_if.sv
// CPU-side register port of the counter bank: write strobe, channel/address
// select, write data, and the registered read data plus status outputs.
interface counter_bank_if #(
  parameter int NCH   = 3,
  parameter int WIDTH = 32,
  parameter int CH_W  = 2
);
  logic              counter_we;
  logic [CH_W-1:0]   counter_ch;
  logic [1:0]        counter_addr;
  logic [WIDTH-1:0]  counter_val;
  logic [WIDTH-1:0]  counter_out;
  logic [NCH-1:0]    counter_zero;
  logic [NCH-1:0]    counter_evt;
  logic              counter_irq;

  // Handshake: there is no valid/ready pair. counter_we qualifies a write in
  // the cycle it is high; counter_out always reflects the ch/addr presented
  // on the previous clock edge.
  modport master (
    output counter_we, counter_ch, counter_addr, counter_val,
    input  counter_out, counter_zero, counter_evt, counter_irq
  );

  modport slave (
    input  counter_we, counter_ch, counter_addr, counter_val,
    output counter_out, counter_zero, counter_evt, counter_irq
  );
endinterface

// File: rtl/counter_bank.sv
// Multi-channel down-counter/timer with one-shot, periodic and free-running
// modes, per-channel tick enables and a registered channel/address read port.
module counter_bank #(
  parameter int NCH   = 3,
  parameter int WIDTH = 32,
  parameter int CH_W  = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] tick,
  counter_bank_if.slave  bus
);

  logic [WIDTH-1:0] cnt      [NCH];
  logic [WIDTH-1:0] cnt_n    [NCH];
  logic [WIDTH-1:0] reload   [NCH];
  logic [WIDTH-1:0] reload_n [NCH];
  logic [1:0]       mode     [NCH];
  logic [1:0]       mode_n   [NCH];
  logic [NCH-1:0]   en, en_n;
  logic [NCH-1:0]   done, done_n;
  logic [NCH-1:0]   evt, evt_n;
  logic [NCH-1:0]   wr_hit;
  logic [NCH-1:0]   zero;
  logic             ch_valid;
  logic [WIDTH-1:0] rd, out_q;

  assign ch_valid = (int'(bus.counter_ch) < NCH);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i]   = bus.counter_we && ch_valid && (int'(bus.counter_ch) == i);
      cnt_n[i]    = cnt[i];
      reload_n[i] = reload[i];
      mode_n[i]   = mode[i];
      en_n[i]     = en[i];
      done_n[i]   = done[i];
      evt_n[i]    = 1'b0;

      // Tick is evaluated against the current en/mode; a same-edge write is layered on top.
      if (en[i] && tick[i]) begin
        case (mode[i])
          2'b10: begin
            cnt_n[i] = cnt[i] - WIDTH'(1);
            if (cnt[i] == '0) evt_n[i] = 1'b1;
          end
          2'b01: begin
            if (cnt[i] > WIDTH'(1)) begin
              cnt_n[i] = cnt[i] - WIDTH'(1);
            end else if (cnt[i] == WIDTH'(1)) begin
              cnt_n[i] = reload[i];
              evt_n[i] = 1'b1;
            end else if (reload[i] != '0) begin
              cnt_n[i] = reload[i];
            end
          end
          default: begin
            if (cnt[i] > WIDTH'(1)) begin
              cnt_n[i] = cnt[i] - WIDTH'(1);
            end else if (cnt[i] == WIDTH'(1)) begin
              cnt_n[i] = '0;
              evt_n[i] = 1'b1;
              en_n[i]  = 1'b0;
            end
          end
        endcase
        if (evt_n[i]) done_n[i] = 1'b1;
      end

      if (wr_hit[i]) begin
        if (bus.counter_addr == 2'd0) begin
          // Load discards the whole tick outcome, including any event.
          cnt_n[i]    = bus.counter_val;
          reload_n[i] = bus.counter_val;
          done_n[i]   = 1'b0;
          en_n[i]     = en[i];
          evt_n[i]    = 1'b0;
        end else if (bus.counter_addr == 2'd1) begin
          en_n[i]   = bus.counter_val[0];
          mode_n[i] = bus.counter_val[2:1];
          if (bus.counter_val[3] && !evt_n[i]) done_n[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < NCH; i++) begin
      zero[i] = (cnt[i] == '0);
      if (ch_valid && (int'(bus.counter_ch) == i)) begin
        case (bus.counter_addr)
          2'd0:    rd = cnt[i];
          2'd1:    rd[3:0] = {done[i], mode[i], en[i]};
          2'd2:    rd = reload[i];
          default: rd = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        reload[i] <= '0;
        mode[i]   <= 2'b00;
      end
      en    <= '0;
      done  <= '0;
      evt   <= '0;
      out_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= cnt_n[i];
        reload[i] <= reload_n[i];
        mode[i]   <= mode_n[i];
      end
      en    <= en_n;
      done  <= done_n;
      evt   <= evt_n;
      out_q <= rd;
    end
  end

  assign bus.counter_out  = out_q;
  assign bus.counter_zero = zero;
  assign bus.counter_evt  = evt;
  assign bus.counter_irq  = |done;

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: per-feature tasks with a read-data
// scoreboard queue and inline comparisons.
module tb_counter_bank;

  localparam int NCH   = 3;
  localparam int WIDTH = 32;
  localparam int CH_W  = 2;

  logic           clk;
  logic           reset_n;
  logic [NCH-1:0] tick;

  counter_bank_if #(.NCH(NCH), .WIDTH(WIDTH), .CH_W(CH_W)) bus ();

  counter_bank #(.NCH(NCH), .WIDTH(WIDTH), .CH_W(CH_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- drivers ----------------
  task automatic wr(input logic [CH_W-1:0] ch, input logic [1:0] addr, input logic [WIDTH-1:0] val);
    bus.counter_we   = 1'b1;
    bus.counter_ch   = ch;
    bus.counter_addr = addr;
    bus.counter_val  = val;
    @(posedge clk); #1;
    bus.counter_we   = 1'b0;
  endtask

  task automatic issue_read(input logic [CH_W-1:0] ch, input logic [1:0] addr, input logic [WIDTH-1:0] exp);
    bus.counter_we   = 1'b0;
    bus.counter_ch   = ch;
    bus.counter_addr = addr;
    exp_q.push_back(exp);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [WIDTH-1:0] got, e;
    wr(2'd0, 2'd0, 32'd5);
    wr(2'd0, 2'd1, 32'h1);
    tick = 3'b001;
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.counter_out !== '0) begin n_fail++; $display("FAIL reset_out: got %h exp 0", bus.counter_out); end
    n_tests++;
    if (bus.counter_evt !== '0 || bus.counter_irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_evt_irq: got evt=%b irq=%b exp 0/0", bus.counter_evt, bus.counter_irq);
    end
    n_tests++;
    if (bus.counter_zero !== 3'b111) begin n_fail++; $display("FAIL reset_zero: got %b exp 111", bus.counter_zero); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_read(2'd0, (i == 2) ? 2'd1 : 2'd0, '0);
      @(posedge clk); #1;
      got = bus.counter_out; e = exp_q.pop_front();
      n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL reset_post_read[%0d]: got %h exp %h", i, got, e); end
      n_tests++;
      if (bus.counter_evt !== '0) begin n_fail++; $display("FAIL reset_post_evt[%0d]: got %b exp 000", i, bus.counter_evt); end
    end
    tick = '0;
  endtask

  task automatic test_oneshot();
    logic [WIDTH-1:0] got, e, m;
    logic exp_e;
    int n_evt = 0;
    wr(2'd0, 2'd0, 32'd3);
    wr(2'd0, 2'd1, 32'h1);
    tick = 3'b001;
    m = 32'd3;
    for (int i = 0; i < 6; i++) begin
      issue_read(2'd0, 2'd0, m);
      exp_e = (m == 32'd1);
      m = (m > 32'd1) ? m - 32'd1 : 32'd0;
      @(posedge clk); #1;
      got = bus.counter_out; e = exp_q.pop_front();
      n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL oneshot_cnt[%0d]: got %h exp %h", i, got, e); end
      n_tests++;
      if (bus.counter_evt[0] !== exp_e) begin n_fail++; $display("FAIL oneshot_evt[%0d]: got %b exp %b", i, bus.counter_evt[0], exp_e); end
      if (bus.counter_evt[0] === 1'b1) n_evt++;
    end
    tick = '0;
    n_tests++;
    if (n_evt !== 1) begin n_fail++; $display("FAIL oneshot_evt_count: got %0d exp 1", n_evt); end
    issue_read(2'd0, 2'd1, 32'h8);
    @(posedge clk); #1;
    got = bus.counter_out; e = exp_q.pop_front();
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL oneshot_ctrl: got %h exp %h", got, e); end
    n_tests++;
    if (bus.counter_zero[0] !== 1'b1 || bus.counter_irq !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_zero_irq: got zero=%b irq=%b exp 1/1", bus.counter_zero[0], bus.counter_irq);
    end
    wr(2'd0, 2'd1, 32'h8);
    n_tests++;
    if (bus.counter_irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_clear_irq: got %b exp 0", bus.counter_irq); end
  endtask

  task automatic test_periodic();
    logic [WIDTH-1:0] got, e, m;
    logic exp_e;
    int n_evt = 0;
    int last = -1;
    wr(2'd1, 2'd0, 32'd4);
    wr(2'd1, 2'd1, 32'h3);
    tick = 3'b010;
    m = 32'd4;
    for (int i = 1; i <= 12; i++) begin
      issue_read(2'd1, 2'd0, m);
      exp_e = (m == 32'd1);
      m = (m == 32'd1) ? 32'd4 : m - 32'd1;
      @(posedge clk); #1;
      got = bus.counter_out; e = exp_q.pop_front();
      n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL periodic_cnt[%0d]: got %h exp %h", i, got, e); end
      n_tests++;
      if (bus.counter_evt[1] !== exp_e) begin n_fail++; $display("FAIL periodic_evt[%0d]: got %b exp %b", i, bus.counter_evt[1], exp_e); end
      if (bus.counter_evt[1] === 1'b1) begin
        if (last >= 0) begin
          n_tests++;
          if (i - last !== 4) begin n_fail++; $display("FAIL periodic_spacing: got %0d exp 4", i - last); end
        end
        last = i;
        n_evt++;
      end
    end
    tick = '0;
    n_tests++;
    if (n_evt !== 3) begin n_fail++; $display("FAIL periodic_evt_count: got %0d exp 3", n_evt); end
    issue_read(2'd1, 2'd0, m);
    @(posedge clk); #1;
    got = bus.counter_out; e = exp_q.pop_front();
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL periodic_reloaded: got %h exp %h", got, e); end
    n_tests++;
    if (bus.counter_irq !== 1'b1) begin n_fail++; $display("FAIL periodic_irq: got %b exp 1", bus.counter_irq); end
    wr(2'd1, 2'd1, 32'h8);
    n_tests++;
    if (bus.counter_irq !== 1'b0) begin n_fail++; $display("FAIL periodic_clear_irq: got %b exp 0", bus.counter_irq); end
  endtask

  task automatic test_freerun();
    logic [WIDTH-1:0] got, e, m;
    logic exp_e;
    wr(2'd2, 2'd0, 32'd1);
    wr(2'd2, 2'd1, 32'h5);
    tick = 3'b100;
    m = 32'd1;
    for (int i = 0; i < 3; i++) begin
      issue_read(2'd2, 2'd0, m);
      exp_e = (m == 32'd0);
      m = m - 32'd1;
      @(posedge clk); #1;
      got = bus.counter_out; e = exp_q.pop_front();
      n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL freerun_cnt[%0d]: got %h exp %h", i, got, e); end
      n_tests++;
      if (bus.counter_evt[2] !== exp_e) begin n_fail++; $display("FAIL freerun_evt[%0d]: got %b exp %b", i, bus.counter_evt[2], exp_e); end
    end
    tick = '0;
    issue_read(2'd2, 2'd0, m);
    @(posedge clk); #1;
    got = bus.counter_out; e = exp_q.pop_front();
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL freerun_hold: got %h exp %h", got, e); end
    wr(2'd2, 2'd1, 32'h8);
  endtask

  task automatic test_collision();
    logic [WIDTH-1:0] got, e;
    wr(2'd0, 2'd1, 32'h1);
    tick = 3'b001;
    wr(2'd0, 2'd0, 32'd7);
    tick = '0;
    issue_read(2'd0, 2'd0, 32'd7);
    @(posedge clk); #1;
    got = bus.counter_out; e = exp_q.pop_front();
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL collide_load: got %h exp %h", got, e); end
    wr(2'd0, 2'd0, 32'd1);
    tick = 3'b001;
    wr(2'd0, 2'd1, 32'h9);
    tick = '0;
    n_tests++;
    if (bus.counter_evt[0] !== 1'b1 || bus.counter_irq !== 1'b1) begin
      n_fail++; $display("FAIL collide_set_wins: got evt=%b irq=%b exp 1/1", bus.counter_evt[0], bus.counter_irq);
    end
    issue_read(2'd0, 2'd1, 32'h9);
    @(posedge clk); #1;
    got = bus.counter_out; e = exp_q.pop_front();
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL collide_ctrl: got %h exp %h", got, e); end
    wr(2'd0, 2'd1, 32'h8);
  endtask

  task automatic test_decode();
    logic [WIDTH-1:0] got, e;
    logic [CH_W-1:0] chs [5];
    logic [1:0] ads [5];
    logic [WIDTH-1:0] exps [5];
    chs = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd2};
    ads = '{2'd0, 2'd3, 2'd2, 2'd2, 2'd2};
    exps = '{32'd0, 32'd0, 32'd1, 32'd4, 32'd1};
    wr(2'd3, 2'd0, 32'h55);
    wr(2'd3, 2'd1, 32'h1);
    for (int i = 0; i < 5; i++) begin
      issue_read(chs[i], ads[i], exps[i]);
      @(posedge clk); #1;
      got = bus.counter_out; e = exp_q.pop_front();
      n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL decode_read[%0d]: got %h exp %h", i, got, e); end
    end
    n_tests++;
    if (bus.counter_irq !== 1'b0 || bus.counter_evt !== '0) begin
      n_fail++; $display("FAIL decode_ignored_write: got irq=%b evt=%b exp 0/000", bus.counter_irq, bus.counter_evt);
    end
    // Read of a register in the same cycle it is written returns the old value.
    issue_read(2'd1, 2'd0, 32'd4);
    bus.counter_we  = 1'b1;
    bus.counter_val = 32'hABCD;
    @(posedge clk); #1;
    bus.counter_we = 1'b0;
    got = bus.counter_out; e = exp_q.pop_front();
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL decode_pre_write: got %h exp %h", got, e); end
    issue_read(2'd1, 2'd0, 32'hABCD);
    @(posedge clk); #1;
    got = bus.counter_out; e = exp_q.pop_front();
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL decode_post_write: got %h exp %h", got, e); end
    wr(2'd1, 2'd2, 32'h1234);
    issue_read(2'd1, 2'd2, 32'hABCD);
    @(posedge clk); #1;
    got = bus.counter_out; e = exp_q.pop_front();
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL decode_reload_ro: got %h exp %h", got, e); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] got, e;
    wr(2'd1, 2'd0, 32'd1);
    wr(2'd1, 2'd1, 32'h3);
    tick = 3'b010;
    for (int i = 0; i < 5; i++) begin
      issue_read(2'd1, 2'd0, 32'd1);
      @(posedge clk); #1;
      got = bus.counter_out; e = exp_q.pop_front();
      n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %h exp %h", i, got, e); end
      n_tests++;
      if (bus.counter_evt !== 3'b010) begin n_fail++; $display("FAIL b2b_evt[%0d]: got %b exp 010", i, bus.counter_evt); end
    end
    tick = '0;
    wr(2'd1, 2'd1, 32'h8);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset_n          = 1'b0;
    tick             = '0;
    bus.counter_we   = 1'b0;
    bus.counter_ch   = '0;
    bus.counter_addr = '0;
    bus.counter_val  = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    test_reset();
    test_oneshot();
    test_periodic();
    test_freerun();
    test_collision();
    test_decode();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
# counter_bank

Parametrised multi-channel down-counter/timer for the CPU's memory-mapped peripheral space, generalising the single-channel counter. All channels run in the `clk` domain and advance on per-channel tick enables rather than separate clocks. Each channel has its own mode (one-shot, periodic auto-reload, free-running wrap), a reload register, a sticky done flag and a one-cycle event pulse. The CPU bus writes and reads the channels through a registered channel/address port.

## Interface
- `NCH`, 3, number of channels (1..2^CH_W)
- `WIDTH`, 32, counter, reload and bus data width (>= 4)
- `CH_W`, 2, channel-select width
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `tick`  in  NCH  per-channel count enable, sampled each `clk` edge, one cycle per count
- `counter_we`  in  1  write strobe
- `counter_ch`  in  CH_W  channel select for both write and read
- `counter_addr`  in  2  0 = count/reload, 1 = control, 2 = reload (read only), 3 = reserved
- `counter_val`  in  WIDTH  write data
- `counter_out`  out  WIDTH  registered read data
- `counter_zero`  out  NCH  level: channel count == 0
- `counter_evt`  out  NCH  one-cycle registered event pulse
- `counter_irq`  out  1  OR of all done flags

## Operation
- Per-channel state: `cnt[WIDTH]`, `reload[WIDTH]`, `mode[1:0]`, `en`, `done`.
- Reset (`reset_n` = 0) clears all state and outputs to 0 immediately. It aborts any count in progress, and no event is generated.
- Write, addr 0: `reload` and `cnt` both load `counter_val`, and `done` clears. `en` and `mode` are unchanged.
- Write, addr 1:
  - `en` <= val[0].
  - `mode` <= val[2:1].
  - If val[3] = 1, `done` clears (write-1-to-clear).
- Writes to addr 2 or 3 have no effect.
- Writes with `counter_ch` >= NCH are ignored.
- Counting happens on a channel only when `en` = 1 and `tick[i]` = 1.
- Mode 00, one-shot (mode 11 behaves identically):
  - `cnt` > 1: decrement.
  - `cnt` == 1: `cnt` <= 0, `done` <= 1, event pulse, `en` <= 0.
  - `cnt` == 0: hold, no event.
- Mode 01, periodic:
  - `cnt` > 1: decrement.
  - `cnt` == 1: `cnt` <= `reload`, `done` <= 1, event pulse. The period is therefore `reload` ticks.
  - `cnt` == 0: if `reload` != 0, `cnt` <= `reload` with no event; if `reload` == 0, hold with no event.
- Mode 10, free-running:
  - `cnt` decrements modulo 2^WIDTH.
  - On 0 -> all-ones: `done` <= 1 and event pulse. `reload` is not used.
- Event pulse: `counter_evt[i]` is 1 for exactly the cycle after the event edge.
- Same channel, same cycle write and tick:
  - Addr 0: the write wins and the tick is discarded.
  - Addr 1: the tick is evaluated with the old `en`/`mode`, and the control write then takes effect. If both set and clear `done` in the same edge, set wins.
- Write and tick on different channels are independent.
- `counter_zero[i]` = (`cnt[i]` == 0), decoded directly from the register.
- `counter_irq` = |`done`.

## Timing
- Read path (registered every cycle regardless of `counter_we`): `counter_out` <= the selected value below, so data is valid 1 cycle after `counter_ch`/`counter_addr` are presented.
  - addr 0: `cnt[ch]`
  - addr 1: {0…, `done`, `mode`, `en`}
  - addr 2: `reload[ch]`
  - addr 3, or `ch` >= NCH: 0
- A read in the same cycle as a write to the same register returns the pre-write value, and the new value on the next cycle.
- Write-to-count latency: the first decrement can occur on the edge after the load edge.
- `counter_evt` and `done`/`counter_irq` assert on the same edge, 1 cycle after the tick that caused the event.
- No tick-rate limit: `tick` may be held high every cycle. In periodic mode with `reload` = 1, an event occurs on every tick.

## Test plan
- Reset values: hold `reset_n` low mid-count (ch0 `cnt` = 5, en = 1) -> `counter_out`, `cnt`, `done`, `counter_evt` and `counter_irq` are all 0 asynchronously, and no `counter_evt` appears after release.
- One-shot: ch0 write addr0 = 3, then addr1 = 0x1, `tick` held high -> `cnt` goes 3,2,1,0; `counter_evt[0]` pulses once; `done` = 1, `en` = 0, `counter_zero[0]` = 1; further ticks give no change.
- Periodic: ch1 addr0 = 4, addr1 = 0x3, `tick[1]` every cycle for 12 cycles -> 3 events exactly 4 ticks apart; `cnt` reloads to 4; addr1 write 0x8 clears `done` and drops `counter_irq`.
- Free-running wrap (WIDTH = 32): ch2 addr0 = 1, mode 10, en = 1 -> ticks give `cnt` 1, 0, 0xFFFFFFFF; event only on the 0 -> 0xFFFFFFFF edge.
- Collisions: write addr0 = 7 to ch0 with `tick[0]` = 1 in the same cycle -> `cnt` = 7 with no decrement; a simultaneous event and addr1 clear on the same channel leaves `done` = 1.
- Read/decoding: read ch = 3 with NCH = 3 -> 0; a write to ch 3 changes nothing; read addr2 returns the last reload value 1 cycle later.
